hsquare_iter: RTL and testbench



---
 rtl/hsquare_iter.sv | 106 ++++++++++
 tb/tb_hsquare_iter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsquare_iter.sv
// Iterative shift-and-add squarer: one operand in flight, result IN_W edges after accept.
// Define HSQUARE_ZERO_GATE_EN to force out_data to zero whenever out_valid is low.
module hsquare_iter #(
  parameter int IN_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*IN_W-1:0] out_data,
  output logic              busy
);

  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [2*IN_W-1:0]   acc_q;
  logic [2*IN_W-1:0]   acc_d;
  logic [2*IN_W-1:0]   mcand_q;
  logic [IN_W-1:0]     mplier_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*IN_W-1:0]   res_q;
  logic                out_valid_q;
  logic                in_ready_q;
  logic                busy_q;

  // Partial product for this iteration; also the final square on the last edge.
  always_comb begin
    acc_d = acc_q;
    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q    <= {{IN_W{1'b0}}, in_data};
            mplier_q   <= in_data;
            acc_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            res_q       <= acc_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

`ifdef HSQUARE_ZERO_GATE_EN
  assign out_data = out_valid_q ? res_q : '0;
`else
  assign out_data = res_q;
`endif

endmodule

// File: tb/tb_hsquare_iter.sv
// Directed and swept checks of hsquare_iter at IN_W=8 and IN_W=12.
module tb_hsquare_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        busy;

  logic        in_valid12 = 1'b0;
  logic        in_ready12;
  logic [11:0] in_data12 = '0;
  logic        out_valid12;
  logic        out_ready12 = 1'b0;
  logic [23:0] out_data12;
  logic        busy12;

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  hsquare_iter #(.IN_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  hsquare_iter #(.IN_W(12)) dut12 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid12), .in_ready(in_ready12), .in_data(in_data12),
    .out_valid(out_valid12), .out_ready(out_ready12), .out_data(out_data12),
    .busy(busy12)
  );

  always #5 clk = ~clk;

`ifdef HSQUARE_ZERO_GATE_EN
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if ((!out_valid && out_data !== 16'd0) || (!out_valid12 && out_data12 !== 24'd0)) begin
        fails++;
        $display("FAIL zero_gate: got %0d/%0d expected 0 while out_valid low", out_data, out_data12);
      end
    end
  end
`endif

  // Drives one operand through the 8-bit DUT; returns edges-to-valid and the result.
  task automatic do_op(input logic [7:0] x, input bit rel, output int lat, output logic [15:0] res);
    in_data = x; in_valid = 1'b1; out_ready = rel;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = ~x;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    res = out_data;
    if (rel) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_op12(input logic [11:0] x, output int lat, output logic [23:0] res);
    in_data12 = x; in_valid12 = 1'b1; out_ready12 = 1'b1;
    @(posedge clk); #1;
    in_valid12 = 1'b0; in_data12 = ~x;
    lat = 0;
    while (!out_valid12 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    res = out_data12;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset8: got rdy=%b vld=%b dat=%0d busy=%b expected 1 0 0 0", in_ready, out_valid, out_data, busy);
    end
    tests++;
    if (in_ready12 !== 1'b1 || out_valid12 !== 1'b0 || out_data12 !== 24'd0 || busy12 !== 1'b0) begin
      fails++;
      $display("FAIL reset12: got rdy=%b vld=%b dat=%0d busy=%b expected 1 0 0 0", in_ready12, out_valid12, out_data12, busy12);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_values();
    logic [7:0]  ops [4] = '{8'd0, 8'd255, 8'd16, 8'd1};
    logic [15:0] exps[4] = '{16'd0, 16'd65025, 16'd256, 16'd1};
    int lat;
    logic [15:0] res;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL ready_before_%0d: got %b expected 1", ops[i], in_ready);
      end
      do_op(ops[i], 1'b1, lat, res);
      tests++;
      if (lat !== 8) begin
        fails++;
        $display("FAIL latency_%0d: got %0d expected 8", ops[i], lat);
      end
      tests++;
      if (res !== exps[i]) begin
        fails++;
        $display("FAIL square_%0d: got %0d expected %0d", ops[i], res, exps[i]);
      end
      tests++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL release_%0d: got vld=%b busy=%b expected 0 0", ops[i], out_valid, busy);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [15:0] res;
    do_op(8'd200, 1'b0, lat, res);
    tests++;
    if (lat !== 8 || res !== 16'd40000) begin
      fails++;
      $display("FAIL bp_result: got lat=%0d dat=%0d expected 8 40000", lat, res);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_data !== 16'd40000 || in_ready !== 1'b0 || busy !== 1'b1) begin
        fails++;
        $display("FAIL bp_hold_%0d: got vld=%b dat=%0d rdy=%b busy=%b expected 1 40000 0 1", c, out_valid, out_data, in_ready, busy);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got vld=%b rdy=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_reject();
    int lat;
    bit seen;
    in_data = 8'd3; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 8'd9;
    repeat (5) @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 5;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    tests++;
    if (lat !== 8 || out_data !== 16'd9) begin
      fails++;
      $display("FAIL busy_reject_result: got lat=%0d dat=%0d expected 8 9", lat, out_data);
    end
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen = 1'b1;
    end
    out_ready = 1'b0;
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL busy_reject_consumed: got activity=%b expected 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [15:0] res;
    bit seen;
    in_data = 8'd100; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_data !== 16'd0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_state: got rdy=%b dat=%0d vld=%b busy=%b expected 1 0 0 0", in_ready, out_data, out_valid, busy);
    end
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort_valid: got out_valid seen=%b expected 0", seen);
    end
    do_op(8'd12, 1'b1, lat, res);
    tests++;
    if (lat !== 8 || res !== 16'd144) begin
      fails++;
      $display("FAIL after_abort: got lat=%0d dat=%0d expected 8 144", lat, res);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] res;
    logic [7:0]  x;
    logic [15:0] expv;
    mon_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      x = 8'($urandom_range(0, 255));
      expv = 16'(x) * 16'(x);
      do_op(x, 1'b1, lat, res);
      tests++;
      if (lat !== 8 || res !== expv) begin
        fails++;
        $display("FAIL sweep8_%0d: got lat=%0d dat=%0d expected 8 %0d", x, lat, res, expv);
      end
    end
    mon_en = 1'b0;
  endtask

  task automatic test_back_to_back_w12();
    int lat;
    logic [23:0] res;
    logic [11:0] x;
    logic [23:0] expv;
    logic [11:0] edge_ops[3] = '{12'd0, 12'd4095, 12'd1};
    mon_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      x = (n < 3) ? edge_ops[n] : 12'($urandom_range(0, 4095));
      expv = 24'(x) * 24'(x);
      do_op12(x, lat, res);
      tests++;
      if (lat !== 12 || res !== expv) begin
        fails++;
        $display("FAIL sweep12_%0d: got lat=%0d dat=%0d expected 12 %0d", x, lat, res, expv);
      end
    end
    mon_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_busy_reject();
    test_reset_mid();
    test_back_to_back();
    test_back_to_back_w12();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
